bram_port_arbiter: RTL and testbench

Shares the single BRAM port between two requesters:
- m0: host-side loader/unloader that fills operand matrices and drains results.
- m1: the PE-array controller that reads operands and writes back results.

The block grants the port to one master at a time using round-robin priority with a bounded burst lock. It muxes address, write data and write enables onto the port, and routes returning read data with a valid strobe to the master that issued the read. It sits between the masters and the BRAM interface in the matrix-multiply IP.

---
 rtl/bram_port_arbiter_pkg.sv | 25 ++
 rtl/bram_port_arbiter_rd_tag_pipe.sv | 41 ++++
 rtl/bram_port_arbiter.sv | 131 +++++++++++++
 tb/tb_bram_port_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_port_arbiter_pkg.sv
// Shared types for the BRAM port arbiter: FSM state encoding, master indices
// and the read-return tag carried through the read-latency pipeline.
package bram_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_GNT0 = 2'd1,
      ST_GNT1 = 2'd2
   } arb_state_t;

   localparam logic M0 = 1'b0;
   localparam logic M1 = 1'b1;

   typedef struct packed {
      logic valid;
      logic master;
   } rd_tag_t;

   localparam rd_tag_t TAG_NONE = '{valid: 1'b0, master: 1'b0};

   function automatic arb_state_t gnt_state(input logic master);
      return master ? ST_GNT1 : ST_GNT0;
   endfunction

endpackage

// File: rtl/bram_port_arbiter_rd_tag_pipe.sv
// Delays a {valid, master} tag by the BRAM read latency so the returning read
// data is flagged to whichever master issued the read, even after a handover.
module rd_tag_pipe
   import bram_port_arbiter_pkg::*;
#(
   parameter int RD_LATENCY = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic push,
   input  logic push_master,
   output logic m0_rdvalid,
   output logic m1_rdvalid
);

   rd_tag_t stage_d [RD_LATENCY];
   rd_tag_t stage_q [RD_LATENCY];

   genvar gi;
   generate
      for (gi = 0; gi < RD_LATENCY; gi++) begin : g_stage
         if (gi == 0) begin : g_head
            assign stage_d[gi] = push ? rd_tag_t'{valid: 1'b1, master: push_master} : TAG_NONE;
         end else begin : g_link
            assign stage_d[gi] = stage_q[gi-1];
         end

         always_ff @(posedge clk) begin
            if (reset) begin
               stage_q[gi] <= TAG_NONE;
            end else begin
               stage_q[gi] <= stage_d[gi];
            end
         end
      end
   endgenerate

   assign m0_rdvalid = stage_q[RD_LATENCY-1].valid && (stage_q[RD_LATENCY-1].master == M0);
   assign m1_rdvalid = stage_q[RD_LATENCY-1].valid && (stage_q[RD_LATENCY-1].master == M1);

endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one BRAM port between the host loader (m0) and
// the PE-array controller (m1), with a bounded burst lock and read-return steering.
module bram_port_arbiter
   import bram_port_arbiter_pkg::*;
#(
   parameter int BRAM_ADDR_WIDTH = 15,
   parameter int BRAM_DATA_WIDTH = 32,
   parameter int BRAM_WE_WIDTH   = 4,
   parameter int MAX_BURST       = 64,
   parameter int BURST_CNT_WIDTH = 7,
   parameter int RD_LATENCY      = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       m0_req,
   input  logic [BRAM_ADDR_WIDTH-1:0] m0_addr,
   input  logic [BRAM_DATA_WIDTH-1:0] m0_wrdata,
   input  logic [BRAM_WE_WIDTH-1:0]   m0_we,
   output logic                       m0_gnt,
   output logic [BRAM_DATA_WIDTH-1:0] m0_rddata,
   output logic                       m0_rdvalid,
   input  logic                       m1_req,
   input  logic [BRAM_ADDR_WIDTH-1:0] m1_addr,
   input  logic [BRAM_DATA_WIDTH-1:0] m1_wrdata,
   input  logic [BRAM_WE_WIDTH-1:0]   m1_we,
   output logic                       m1_gnt,
   output logic [BRAM_DATA_WIDTH-1:0] m1_rddata,
   output logic                       m1_rdvalid,
   output logic [BRAM_ADDR_WIDTH-1:0] bram_addr,
   output logic [BRAM_DATA_WIDTH-1:0] bram_wrdata,
   output logic [BRAM_WE_WIDTH-1:0]   bram_we,
   output logic                       bram_en,
   input  logic [BRAM_DATA_WIDTH-1:0] bram_rddata
);

   localparam logic [BURST_CNT_WIDTH-1:0] MAX_CNT = BURST_CNT_WIDTH'(MAX_BURST);

   arb_state_t                 state_reg, state_next;
   logic                       last_gnt_reg, last_gnt_next;
   logic [BURST_CNT_WIDTH-1:0] cnt_reg, cnt_next, cnt_inc;
   logic [1:0]                 req_vec;
   logic                       own, other;

   assign req_vec = {m1_req, m0_req};
   assign own     = (state_reg == ST_GNT1);
   assign other   = ~own;
   assign m0_gnt  = (state_reg == ST_GNT0);
   assign m1_gnt  = (state_reg == ST_GNT1);

   // Saturates so a lone master can keep streaming past the burst limit.
   assign cnt_inc = (cnt_reg >= MAX_CNT) ? MAX_CNT : cnt_reg + 1'b1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= ST_IDLE;
         last_gnt_reg <= M1;
         cnt_reg      <= '0;
      end else begin
         state_reg    <= state_next;
         last_gnt_reg <= last_gnt_next;
         cnt_reg      <= cnt_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      last_gnt_next = last_gnt_reg;
      cnt_next      = cnt_reg;
      case (state_reg)
         ST_IDLE: begin
            if (m0_req && (!m1_req || last_gnt_reg == M1)) begin
               state_next    = ST_GNT0;
               last_gnt_next = M0;
            end else if (m1_req) begin
               state_next    = ST_GNT1;
               last_gnt_next = M1;
            end
         end
         ST_GNT0, ST_GNT1: begin
            if (!req_vec[own]) begin
               cnt_next   = '0;
               state_next = req_vec[other] ? gnt_state(other) : ST_IDLE;
            end else if (cnt_inc == MAX_CNT && req_vec[other]) begin
               cnt_next      = '0;
               state_next    = gnt_state(other);
               last_gnt_next = own;
            end else begin
               cnt_next = cnt_inc;
            end
         end
         default: begin
            state_next = ST_IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   // Only the granted master that is also requesting reaches the port.
   always_comb begin
      bram_en     = 1'b0;
      bram_addr   = '0;
      bram_wrdata = '0;
      bram_we     = '0;
      if (m0_gnt && m0_req) begin
         bram_en     = 1'b1;
         bram_addr   = m0_addr;
         bram_wrdata = m0_wrdata;
         bram_we     = m0_we;
      end else if (m1_gnt && m1_req) begin
         bram_en     = 1'b1;
         bram_addr   = m1_addr;
         bram_wrdata = m1_wrdata;
         bram_we     = m1_we;
      end
   end

   rd_tag_pipe #(
      .RD_LATENCY (RD_LATENCY)
   ) u_rd_tag_pipe (
      .clk         (clk),
      .reset       (reset),
      .push        (bram_en && (bram_we == '0)),
      .push_master (own),
      .m0_rdvalid  (m0_rdvalid),
      .m1_rdvalid  (m1_rdvalid)
   );

   assign m0_rddata = bram_rddata;
   assign m1_rddata = bram_rddata;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level model of the arbitration rules.
module tb_bram_port_arbiter;

   localparam int AW   = 15;
   localparam int DW   = 32;
   localparam int WW   = 4;
   localparam int MAXB = 64;
   localparam int RDL  = 2;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic          m_req  [2];
   logic [AW-1:0] m_addr [2];
   logic [DW-1:0] m_wd   [2];
   logic [WW-1:0] m_we   [2];

   logic          m0_gnt, m1_gnt, m0_rdvalid, m1_rdvalid, bram_en;
   logic [DW-1:0] m0_rddata, m1_rddata, bram_wrdata, bram_rddata;
   logic [AW-1:0] bram_addr;
   logic [WW-1:0] bram_we;

   bram_port_arbiter #(
      .BRAM_ADDR_WIDTH (AW), .BRAM_DATA_WIDTH (DW), .BRAM_WE_WIDTH (WW),
      .MAX_BURST (MAXB), .BURST_CNT_WIDTH (7), .RD_LATENCY (RDL)
   ) dut (
      .clk (clk), .reset (reset),
      .m0_req (m_req[0]), .m0_addr (m_addr[0]), .m0_wrdata (m_wd[0]), .m0_we (m_we[0]),
      .m0_gnt (m0_gnt), .m0_rddata (m0_rddata), .m0_rdvalid (m0_rdvalid),
      .m1_req (m_req[1]), .m1_addr (m_addr[1]), .m1_wrdata (m_wd[1]), .m1_we (m_we[1]),
      .m1_gnt (m1_gnt), .m1_rddata (m1_rddata), .m1_rdvalid (m1_rdvalid),
      .bram_addr (bram_addr), .bram_wrdata (bram_wrdata), .bram_we (bram_we),
      .bram_en (bram_en), .bram_rddata (bram_rddata)
   );

   // Simple BRAM with read-first behaviour and RDL-cycle read latency.
   logic [DW-1:0] mem [64];
   logic [DW-1:0] rd_pipe [RDL];
   always @(posedge clk) begin
      if (bram_en) begin
         for (int b = 0; b < WW; b++)
            if (bram_we[b]) mem[bram_addr[7:2]][8*b +: 8] <= bram_wrdata[8*b +: 8];
      end
      rd_pipe[0] <= mem[bram_addr[7:2]];
      for (int i = 1; i < RDL; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign bram_rddata = rd_pipe[RDL-1];

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: actual %0h required %0h", name, act, req);
   endtask

   // ---------------- reference model ----------------
   logic          model_on = 1'b0;
   int            cyc = 0;
   int            owner = -1;
   int            run = 0;
   int            tie_fav = 0;
   logic [1:0]    ret_mask [8];
   logic [DW-1:0] ref_mem [64];
   logic [DW-1:0] q0 [$];
   logic [DW-1:0] q1 [$];
   int            issued0 = 0, issued1 = 0, dropped0 = 0, dropped1 = 0;
   int            dut_rv0 = 0, dut_rv1 = 0;
   int            wait0 = 0, wait1 = 0, max_wait = 0;
   int            xm, om, ym;
   logic [1:0]    rv;
   logic          e_en;
   logic [WW-1:0] e_we;
   logic [AW-1:0] e_addr;
   logic [DW-1:0] e_wd, d;

   initial begin
      @(posedge clk);
      model_on = 1'b1;
   end

   always @(negedge clk) begin
      if (model_on) begin
         xm = -1;
         if (owner >= 0 && m_req[owner]) xm = owner;
         rv = ret_mask[cyc % 8];
         e_en = 1'b0; e_we = '0; e_addr = '0; e_wd = '0;
         if (xm >= 0) begin
            e_en = 1'b1; e_we = m_we[xm]; e_addr = m_addr[xm]; e_wd = m_wd[xm];
         end
         check($sformatf("port_cyc%0d", cyc),
               {m0_gnt, m1_gnt, m0_rdvalid, m1_rdvalid, bram_en, bram_we, bram_addr, bram_wrdata},
               {owner == 0, owner == 1, rv[0], rv[1], e_en, e_we, e_addr, e_wd});
         check($sformatf("single_gnt_cyc%0d", cyc), m0_gnt & m1_gnt, 0);
         if (rv[0] && q0.size() > 0) begin
            d = q0.pop_front();
            check($sformatf("rddata_m0_cyc%0d", cyc), m0_rddata, d);
         end
         if (rv[1] && q1.size() > 0) begin
            d = q1.pop_front();
            check($sformatf("rddata_m1_cyc%0d", cyc), m1_rddata, d);
         end
         dut_rv0 += int'(m0_rdvalid);
         dut_rv1 += int'(m1_rdvalid);
         wait0 = (!reset && m_req[0] && !m0_gnt) ? wait0 + 1 : 0;
         wait1 = (!reset && m_req[1] && !m1_gnt) ? wait1 + 1 : 0;
         if (wait0 > max_wait) max_wait = wait0;
         if (wait1 > max_wait) max_wait = wait1;

         if (xm >= 0 && m_we[xm] != '0) begin
            for (int b = 0; b < WW; b++)
               if (m_we[xm][b]) ref_mem[m_addr[xm][7:2]][8*b +: 8] = m_wd[xm][8*b +: 8];
         end
         if (reset) begin
            dropped0 += q0.size();
            dropped1 += q1.size();
            q0.delete();
            q1.delete();
            for (int i = 0; i < 8; i++) ret_mask[i] = 2'b00;
            owner = -1; run = 0; tie_fav = 0;
         end else begin
            ret_mask[cyc % 8] = 2'b00;
            if (xm >= 0 && m_we[xm] == '0) begin
               ret_mask[(cyc + RDL) % 8][xm] = 1'b1;
               if (xm == 0) begin q0.push_back(ref_mem[m_addr[0][7:2]]); issued0++; end
               else         begin q1.push_back(ref_mem[m_addr[1][7:2]]); issued1++; end
            end
            if (owner < 0) begin
               if (m_req[0] && m_req[1]) begin owner = tie_fav; tie_fav = 1 - tie_fav; end
               else if (m_req[0]) begin owner = 0; tie_fav = 1; end
               else if (m_req[1]) begin owner = 1; tie_fav = 0; end
            end else begin
               om = owner; ym = 1 - owner;
               if (!m_req[om]) begin
                  owner = m_req[ym] ? ym : -1;
                  run = 0;
               end else begin
                  run = (run < MAXB) ? run + 1 : MAXB;
                  if (run == MAXB && m_req[ym]) begin owner = ym; run = 0; tie_fav = ym; end
               end
            end
         end
         cyc++;
      end
   end

   // ---------------- stimulus ----------------
   logic          s_g0, s_g1, s_en, s_rv0, s_rv1;
   logic [WW-1:0] s_we;
   logic [AW-1:0] s_addr;
   logic [DW-1:0] s_wd, s_rd;
   logic          s_xf [2];
   int            left [2];

   task automatic tick();
      @(negedge clk);
      s_g0 = m0_gnt; s_g1 = m1_gnt; s_en = bram_en; s_we = bram_we;
      s_addr = bram_addr; s_wd = bram_wrdata; s_rd = m0_rddata;
      s_rv0 = m0_rdvalid; s_rv1 = m1_rdvalid;
      s_xf[0] = m_req[0] & m0_gnt;
      s_xf[1] = m_req[1] & m1_gnt;
      @(posedge clk);
      #1;
   endtask

   task automatic new_op(input int m, input bit rd_only);
      m_addr[m] = {7'b0, 6'($urandom_range(0, 63)), 2'b00};
      m_we[m]   = (rd_only || $urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      m_wd[m]   = $urandom;
   endtask

   task automatic rand_step();
      for (int m = 0; m < 2; m++) begin
         if (m_req[m]) begin
            if (s_xf[m]) begin
               left[m]--;
               if (left[m] == 0) m_req[m] = 1'b0;
               else new_op(m, 1'b0);
            end
         end else if ($urandom_range(0, 3) == 0) begin
            left[m] = $urandom_range(1, 100);
            new_op(m, 1'b0);
            m_req[m] = 1'b1;
         end
      end
      reset = ($urandom_range(0, 1999) == 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "watchdog expired");
   end

   int cnt1, cnt0, rv1n, rv64_cyc, last_g1_cyc, first_run, tcyc;
   bit first_done, gap, stale;

   initial begin
      for (int i = 0; i < 64; i++) begin mem[i] = '0; ref_mem[i] = '0; end
      for (int i = 0; i < RDL; i++) rd_pipe[i] = '0;
      for (int i = 0; i < 8; i++) ret_mask[i] = 2'b00;
      for (int m = 0; m < 2; m++) begin
         m_req[m] = 1'b0; m_addr[m] = '0; m_wd[m] = '0; m_we[m] = '0; left[m] = 0;
      end

      // Reset state and a single write then read by m0.
      tick(); tick();
      check("reset_state", {s_g0, s_g1, s_en, s_we, s_rv0, s_rv1, s_addr, s_wd}, 0);
      reset = 1'b0;
      m_addr[0] = 15'h0010; m_we[0] = 4'hF; m_wd[0] = 32'hDEADBEEF; m_req[0] = 1'b1;
      tick();
      check("gnt_not_same_cycle", s_g0, 1'b0);
      tick();
      check("gnt_after_1", s_g0, 1'b1);
      check("wr_port", {s_en, s_we, s_addr, s_wd}, {1'b1, 4'hF, 15'h0010, 32'hDEADBEEF});
      m_we[0] = 4'h0;
      tick();
      m_req[0] = 1'b0;
      tick();
      check("rdvalid_not_early", s_rv0, 1'b0);
      tick();
      check("rd_return", {s_rv0, s_rv1, s_rd}, {1'b1, 1'b0, 32'hDEADBEEF});

      // Simultaneous requests: m0 first, direct handover, next tie to m1.
      reset = 1'b1; tick(); reset = 1'b0;
      m_addr[1] = 15'h0010; m_we[1] = 4'h0; m_req[0] = 1'b1; m_req[1] = 1'b1;
      tick(); tick();
      check("tie_first_m0", {s_g0, s_g1}, 2'b10);
      m_req[0] = 1'b0;
      tick(); tick();
      check("handover_no_gap", {s_g0, s_g1}, 2'b01);
      m_req[1] = 1'b0;
      tick(); tick();
      m_req[0] = 1'b1; m_req[1] = 1'b1;
      tick(); tick();
      check("second_tie_m1", {s_g0, s_g1}, 2'b01);
      m_req[0] = 1'b0; m_req[1] = 1'b0;
      tick(); tick();

      // m1 streams 100 reads while m0 keeps requesting.
      new_op(1, 1'b1); m_req[1] = 1'b1;
      tick();
      m_addr[0] = 15'h0020; m_we[0] = 4'hF; m_wd[0] = 32'h12345678; m_req[0] = 1'b1;
      cnt1 = 0; cnt0 = 0; rv1n = 0; rv64_cyc = -1; last_g1_cyc = -1; first_run = -1;
      first_done = 1'b0; tcyc = 0;
      while (cnt1 < 100 && tcyc < 400) begin
         tick();
         if (s_rv1) begin rv1n++; if (rv1n == 64) rv64_cyc = tcyc; end
         if (!first_done && s_g1) last_g1_cyc = tcyc;
         if (!first_done && !s_g1 && cnt1 > 0) begin
            first_done = 1'b1;
            first_run = cnt1;
            check("burst_handover_to_m0", s_g0, 1'b1);
         end
         if (s_xf[1]) begin
            cnt1++;
            if (cnt1 == 100) m_req[1] = 1'b0; else new_op(1, 1'b1);
         end
         if (s_xf[0]) begin
            cnt0++;
            if (cnt0 == 3) m_req[0] = 1'b0; else new_op(0, 1'b0);
         end
         tcyc++;
      end
      check("burst_cap_64", first_run, MAXB);
      check("rv64_after_gnt_fall", rv64_cyc > last_g1_cyc, 1'b1);
      check("m1_regranted_100", cnt1, 100);
      check("m0_served_3", cnt0, 3);
      tick(); tick(); tick();

      // m1 bursts 80 with m0 idle: no forced release.
      new_op(1, 1'b0); m_req[1] = 1'b1;
      cnt1 = 0; gap = 1'b0; tcyc = 0;
      while (cnt1 < 80 && tcyc < 200) begin
         tick();
         if (cnt1 > 0 && !s_g1) gap = 1'b1;
         if (s_xf[1]) begin
            cnt1++;
            if (cnt1 == 80) m_req[1] = 1'b0; else new_op(1, 1'b0);
         end
         tcyc++;
      end
      check("lone_burst_80", cnt1, 80);
      check("lone_burst_no_gap", gap, 1'b0);
      tick(); tick(); tick();

      // Reset in the middle of a read burst.
      new_op(0, 1'b1); m_req[0] = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (s_xf[0]) new_op(0, 1'b1);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      check("reset_midburst", {s_g0, s_g1, s_en, s_rv0, s_rv1}, 0);
      m_req[0] = 1'b0;
      stale = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         stale = stale | s_rv0 | s_rv1;
      end
      check("no_stale_rdvalid", stale, 1'b0);

      // Randomised traffic.
      for (int i = 0; i < 10000; i++) begin
         tick();
         rand_step();
      end
      reset = 1'b0; m_req[0] = 1'b0; m_req[1] = 1'b0;
      for (int i = 0; i < 10; i++) tick();

      check("reads_returned_m0", dut_rv0, issued0 - dropped0);
      check("reads_returned_m1", dut_rv1, issued1 - dropped1);
      check("max_wait_bound", max_wait <= MAXB + 1, 1'b1);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
